pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives STALL/CLEAR of the four

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_loaduse_cmp.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encodings and stall/clear vector bit indices.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MDWAIT  = 2'd2,
        ST_MEMWAIT = 2'd3
    } hz_state_t;

    localparam int R_IFID  = 0;
    localparam int R_IDEX  = 1;
    localparam int R_EXMEM = 2;
    localparam int R_MEMWB = 3;
    localparam int N_REGS  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_cmp.sv
// Load-use hazard compare between the ID sources and the EX load.
// Also usable by the forwarding unit.
module hazard_loaduse_cmp #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hit
);

    logic m1;
    logic m2;

    assign m1  = id_rs1_used && (id_rs1 == ex_rd);
    assign m2  = id_rs2_used && (id_rs2 == ex_rd);
    assign hit = ex_valid && ex_is_load && (ex_rd != '0) && (m1 || m2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use,
// redirects, mul/div waits, memory wait states with timeout.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             stall_memwb,
    output logic             clr_ifid,
    output logic             clr_idex,
    output logic             clr_exmem,
    output logic             clr_memwb,
    output logic             mem_err,
    output logic [31:0]      perf_stall
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    hz_state_t         state;
    hz_state_t         state_d;
    logic [TO_W-1:0]   to_cnt;
    logic              md_pend;
    logic              is_init;
    logic              lu_hit;
    logic              mem_busy;
    logic              tmo;
    logic              mem_hold;
    logic              md_busy;
    logic [N_REGS-1:0] stall_v;
    logic [N_REGS-1:0] clr_v;

    hazard_loaduse_cmp #(.REG_W(REG_W)) u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .hit         (lu_hit)
    );

    assign is_init  = (state == ST_INIT);
    assign mem_busy = !is_init && mem_req && !mem_ack;
    assign tmo      = mem_busy && (to_cnt == TO_LAST);
    // A timed-out access behaves as acked: the pipe moves on, MEM is killed.
    assign mem_hold = mem_busy && !tmo;
    assign md_busy  = !is_init && (md_start || (md_pend && !md_done));

    always_comb begin
        stall_v  = '0;
        clr_v    = '0;
        pc_stall = 1'b0;
        mem_err  = 1'b0;
        if (is_init) begin
            clr_v    = '1;
            pc_stall = 1'b1;
        end else begin
            mem_err = tmo;
            if (mem_hold) begin
                pc_stall         = 1'b1;
                stall_v[R_IFID]  = 1'b1;
                stall_v[R_IDEX]  = 1'b1;
                stall_v[R_EXMEM] = 1'b1;
                clr_v[R_MEMWB]   = 1'b1;
            end else if (md_busy) begin
                pc_stall         = 1'b1;
                stall_v[R_IFID]  = 1'b1;
                stall_v[R_IDEX]  = 1'b1;
                clr_v[R_EXMEM]   = 1'b1;
            end else if (ex_redirect) begin
                clr_v[R_IFID]    = 1'b1;
                clr_v[R_IDEX]    = 1'b1;
            end else if (lu_hit) begin
                pc_stall         = 1'b1;
                stall_v[R_IFID]  = 1'b1;
                clr_v[R_IDEX]    = 1'b1;
            end
            if (tmo) clr_v[R_MEMWB] = 1'b1;
        end
    end

    assign stall_ifid  = stall_v[R_IFID];
    assign stall_idex  = stall_v[R_IDEX];
    assign stall_exmem = stall_v[R_EXMEM];
    assign stall_memwb = stall_v[R_MEMWB];
    assign clr_ifid    = clr_v[R_IFID];
    assign clr_idex    = clr_v[R_IDEX];
    assign clr_exmem   = clr_v[R_EXMEM];
    assign clr_memwb   = clr_v[R_MEMWB];

    always_comb begin
        state_d = ST_RUN;
        if (is_init)       state_d = ST_RUN;
        else if (mem_hold) state_d = ST_MEMWAIT;
        else if (md_busy)  state_d = ST_MDWAIT;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_INIT;
            to_cnt     <= '0;
            md_pend    <= 1'b0;
            perf_stall <= '0;
        end else begin
            state   <= state_d;
            md_pend <= md_busy;
            to_cnt  <= mem_hold ? to_cnt + 1'b1 : '0;
            if (pc_stall && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven scoreboard bench for pipe_hazard_ctrl.
// Output vector: {pc,s_ifid,s_idex,s_exmem,s_memwb,c_ifid,c_idex,c_exmem,c_memwb,err}.
module tb_pipe_hazard_ctrl;

    localparam logic [9:0] O_IDLE = 10'b0000000000;
    localparam logic [9:0] O_INIT = 10'b1000011110;
    localparam logic [9:0] O_LU   = 10'b1100001000;
    localparam logic [9:0] O_RED  = 10'b0000011000;
    localparam logic [9:0] O_MD   = 10'b1110000100;
    localparam logic [9:0] O_MEM  = 10'b1111000010;
    localparam logic [9:0] O_TMO  = 10'b0000000011;

    typedef struct {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       exv;
        logic       ld;
        logic [4:0] rd;
        logic       red;
        logic       mds;
        logic       mdd;
        logic       mrq;
        logic       mak;
        logic [9:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_rs1_used = 0, id_rs2_used = 0, ex_valid = 0, ex_is_load = 0;
    logic        ex_redirect = 0, md_start = 0, md_done = 0, mem_req = 0, mem_ack = 0;
    logic        pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic        clr_ifid, clr_idex, clr_exmem, clr_memwb, mem_err;
    logic [31:0] perf_stall;

    int          errs = 0;
    int          checks = 0;
    int unsigned exp_perf = 0;
    logic [9:0]  exp_q[$];
    vec_t        tbl[$];

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(8), .TO_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .md_start(md_start), .md_done(md_done),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc_stall), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
        .clr_ifid(clr_ifid), .clr_idex(clr_idex), .clr_exmem(clr_exmem),
        .clr_memwb(clr_memwb), .mem_err(mem_err), .perf_stall(perf_stall)
    );

    function automatic logic [9:0] outs();
        return {pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                clr_ifid, clr_idex, clr_exmem, clr_memwb, mem_err};
    endfunction

    function automatic vec_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic exv, logic ld, logic [4:0] rd, logic red,
                                logic mds, logic mdd, logic mrq, logic mak,
                                logic [9:0] exp);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.exv = exv; v.ld = ld; v.rd = rd; v.red = red;
        v.mds = mds; v.mdd = mdd; v.mrq = mrq; v.mak = mak;
        v.exp = exp;
        return v;
    endfunction

    function automatic vec_t ctl(logic red, logic mds, logic mdd, logic mrq,
                                 logic mak, logic [9:0] exp);
        return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                  red, mds, mdd, mrq, mak, exp);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(vec_t v);
        id_rs1 = v.rs1; id_rs1_used = v.u1;
        id_rs2 = v.rs2; id_rs2_used = v.u2;
        ex_valid = v.exv; ex_is_load = v.ld; ex_rd = v.rd;
        ex_redirect = v.red; md_start = v.mds; md_done = v.mdd;
        mem_req = v.mrq; mem_ack = v.mak;
    endtask

    task automatic step(vec_t v, string nm);
        logic [9:0] e;
        @(negedge CLK);
        drive(v);
        exp_q.push_back(v.exp);
        #2;
        e = exp_q.pop_front();
        chk(nm, {22'd0, outs()}, {22'd0, e});
        chk({nm, "_perf"}, perf_stall, exp_perf);
        @(posedge CLK);
        if (!RST) exp_perf += e[9];
    endtask

    initial begin
        // post-reset flush, then load-use variants
        tbl.push_back(ctl(0, 0, 0, 0, 0, O_INIT));
        tbl.push_back(ctl(0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk(5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, O_LU));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk(3, 1, 7, 1, 1, 1, 7, 0, 0, 0, 0, 0, O_LU));
        tbl.push_back(mk(3, 1, 7, 0, 1, 1, 7, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk(9, 1, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, O_IDLE));
        tbl.push_back(mk(5, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, O_RED));
        // mul/div: start + 4 wait cycles, release on done
        tbl.push_back(ctl(0, 1, 0, 0, 0, O_MD));
        for (int i = 0; i < 4; i++) tbl.push_back(ctl(0, 0, 0, 0, 0, O_MD));
        tbl.push_back(ctl(0, 0, 1, 0, 0, O_IDLE));
        tbl.push_back(ctl(0, 0, 1, 0, 0, O_IDLE));
        tbl.push_back(ctl(1, 1, 0, 0, 0, O_MD));
        tbl.push_back(ctl(1, 0, 1, 0, 0, O_RED));
        // memory wait, ack after 3 busy cycles
        for (int i = 0; i < 3; i++) tbl.push_back(ctl(0, 0, 0, 1, 0, O_MEM));
        tbl.push_back(ctl(0, 0, 0, 1, 1, O_IDLE));
        tbl.push_back(ctl(1, 0, 0, 1, 0, O_MEM));
        tbl.push_back(ctl(1, 0, 0, 1, 1, O_RED));
        // memory wait nested in a pending mul/div
        tbl.push_back(ctl(0, 1, 0, 0, 0, O_MD));
        tbl.push_back(ctl(0, 0, 0, 1, 0, O_MEM));
        tbl.push_back(ctl(0, 0, 0, 1, 1, O_MD));
        tbl.push_back(ctl(0, 0, 1, 0, 0, O_IDLE));
        // timeout on busy cycle 8, then a fresh access starts from zero
        for (int i = 0; i < 7; i++) tbl.push_back(ctl(0, 0, 0, 1, 0, O_MEM));
        tbl.push_back(ctl(0, 0, 0, 1, 0, O_TMO));
        tbl.push_back(ctl(0, 0, 0, 0, 0, O_IDLE));
        for (int i = 0; i < 7; i++) tbl.push_back(ctl(0, 0, 0, 1, 0, O_MEM));
        tbl.push_back(ctl(0, 0, 0, 1, 1, O_IDLE));

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_outs", {22'd0, outs()}, {22'd0, O_INIT});
        chk("rst_perf", perf_stall, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("v%0d", i));

        // asynchronous reset in the middle of a memory wait
        for (int i = 0; i < 3; i++)
            step(ctl(0, 0, 0, 1, 0, O_MEM), $sformatf("mw%0d", i));
        @(negedge CLK);
        drive(ctl(0, 0, 0, 1, 0, O_MEM));
        #1 RST = 1'b1;
        #1;
        chk("arst_outs", {22'd0, outs()}, {22'd0, O_INIT});
        chk("arst_perf", perf_stall, 32'd0);
        exp_perf = 0;
        @(posedge CLK);
        #1 RST = 1'b0;
        step(ctl(0, 0, 0, 1, 0, O_INIT), "arst_flush");
        step(ctl(0, 0, 0, 1, 0, O_MEM), "arst_mem");
        step(ctl(0, 0, 0, 0, 0, O_IDLE), "arst_idle");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
